// File: rtl/bcd_field_reg.sv
// bcd_field_reg: two-digit BCD time field with edit, RTC load, tick carry and dirty flag; BCD_FIELD_AUTO_REPEAT_EN adds hold-to-repeat
module bcd_field_reg #(
    parameter logic [7:0] MIN_BCD = 8'h00,
    parameter logic [7:0] MAX_BCD = 8'h59,
    parameter logic [7:0] RST_BCD = 8'h00
`ifdef BCD_FIELD_AUTO_REPEAT_EN
    ,
    parameter logic [15:0] REPEAT_DLY = 16'd50000,
    parameter logic [15:0] REPEAT_PER = 16'd10000
`endif
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       UP,
    input  logic       DOWN,
    input  logic       Modificando,
    input  logic       Actualizar,
    input  logic       TICK,
    input  logic       WR_ACK,
    input  logic [7:0] DATA_in,
    output logic [7:0] DATA_out,
    output logic       CARRY,
    output logic       DIRTY,
    output logic       LOAD_ERR
);
    localparam logic [7:0] SPAN = MAX_BCD - MIN_BCD;
    logic       up_q, dn_q, up_step, dn_step, rep_step, step, step_up;
    logic       load, load_ok, tk;
    logic [7:0] inc_val, dec_val, data_n;
`ifdef BCD_FIELD_AUTO_REPEAT_EN
    logic [15:0] cnt;
    logic        rep_ph, held;
    // a button held steadily in edit mode fires after REPEAT_DLY cycles, then every REPEAT_PER
    always_comb begin
        held     = Modificando & ((UP & up_q & ~DOWN) | (DOWN & dn_q & ~UP));
        rep_step = held & (cnt == (rep_ph ? REPEAT_PER : REPEAT_DLY) - 16'd1);
    end
    // repeat counter restarts whenever the hold is broken
    always_ff @(posedge CLK) begin
        if (RST || !held) begin
            cnt    <= '0;
            rep_ph <= 1'b0;
        end else if (rep_step) begin
            cnt    <= '0;
            rep_ph <= 1'b1;
        end else begin
            cnt    <= cnt + 16'd1;
        end
    end
`else
    assign rep_step = 1'b0;
`endif
    // step detection, BCD neighbours, load validation and next-value selection
    always_comb begin
        up_step = UP & ~up_q;
        dn_step = DOWN & ~dn_q & ~UP;
        step    = Modificando & (up_step | dn_step | rep_step);
        step_up = up_step | (rep_step & UP);
        inc_val = DATA_out == MAX_BCD ? MIN_BCD :
                  DATA_out[3:0] == 4'd9 ? {DATA_out[7:4] + 4'd1, 4'd0} : {DATA_out[7:4], DATA_out[3:0] + 4'd1};
        dec_val = DATA_out == MIN_BCD ? MAX_BCD :
                  DATA_out[3:0] == 4'd0 ? {DATA_out[7:4] - 4'd1, 4'd9} : {DATA_out[7:4], DATA_out[3:0] - 4'd1};
        load    = ~Modificando & Actualizar;
        load_ok = DATA_in[7:4] <= 4'd9 && DATA_in[3:0] <= 4'd9 && 8'(DATA_in - MIN_BCD) <= SPAN;
        tk      = ~Modificando & ~Actualizar & TICK;
        data_n  = step ? (step_up ? inc_val : dec_val) : (load & load_ok) ? DATA_in : tk ? inc_val : DATA_out;
    end
    // field value, pulses, dirty flag and button history
    always_ff @(posedge CLK) begin
        if (RST) begin
            DATA_out <= RST_BCD;
            CARRY    <= 1'b0;
            DIRTY    <= 1'b0;
            LOAD_ERR <= 1'b0;
            up_q     <= 1'b0;
            dn_q     <= 1'b0;
        end else begin
            DATA_out <= data_n;
            CARRY    <= tk & (DATA_out == MAX_BCD);
            DIRTY    <= step | (DIRTY & ~WR_ACK & ~(load & load_ok));
            LOAD_ERR <= load & ~load_ok;
            up_q     <= UP;
            dn_q     <= DOWN;
        end
    end
endmodule

// File: tb/tb_bcd_field_reg.sv
// tb_bcd_field_reg: directed stimulus against a decimal behavioural model of several field configurations
module tb_bcd_field_reg;
`ifdef BCD_FIELD_AUTO_REPEAT_EN
    localparam int NM = 3;
`else
    localparam int NM = 2;
`endif
    logic       CLK = 1'b0;
    logic       RST, UP, DOWN, Mod, Act, TICK, WR_ACK;
    logic [7:0] DATA_in;
    logic [7:0] dout[NM];
    logic       carry[NM], dirty[NM], lerr[NM];

    int mn[3]  = '{0, 1, 0};
    int mx[3]  = '{59, 12, 59};
    int rs[3]  = '{0, 1, 0};
    int dly[3] = '{50000, 50000, 10};
    int per[3] = '{10000, 10000, 4};
    int m_val[3];
    bit m_carry[3], m_dirty[3], m_lerr[3];
    bit pu, pd, armed;
    int hk;
    int n_vec = 0, n_err = 0;

    always #5 CLK = ~CLK;

    bcd_field_reg #(.MIN_BCD(8'h00), .MAX_BCD(8'h59), .RST_BCD(8'h00)) dut_a (
        .CLK(CLK), .RST(RST), .UP(UP), .DOWN(DOWN), .Modificando(Mod), .Actualizar(Act),
        .TICK(TICK), .WR_ACK(WR_ACK), .DATA_in(DATA_in), .DATA_out(dout[0]),
        .CARRY(carry[0]), .DIRTY(dirty[0]), .LOAD_ERR(lerr[0]));
    bcd_field_reg #(.MIN_BCD(8'h01), .MAX_BCD(8'h12), .RST_BCD(8'h01)) dut_b (
        .CLK(CLK), .RST(RST), .UP(UP), .DOWN(DOWN), .Modificando(Mod), .Actualizar(Act),
        .TICK(TICK), .WR_ACK(WR_ACK), .DATA_in(DATA_in), .DATA_out(dout[1]),
        .CARRY(carry[1]), .DIRTY(dirty[1]), .LOAD_ERR(lerr[1]));
`ifdef BCD_FIELD_AUTO_REPEAT_EN
    bcd_field_reg #(.MIN_BCD(8'h00), .MAX_BCD(8'h59), .RST_BCD(8'h00),
                    .REPEAT_DLY(16'd10), .REPEAT_PER(16'd4)) dut_r (
        .CLK(CLK), .RST(RST), .UP(UP), .DOWN(DOWN), .Modificando(Mod), .Actualizar(Act),
        .TICK(TICK), .WR_ACK(WR_ACK), .DATA_in(DATA_in), .DATA_out(dout[2]),
        .CARRY(carry[2]), .DIRTY(dirty[2]), .LOAD_ERR(lerr[2]));
`endif

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + v % 10);
    endfunction

    task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // field values held as plain decimal integers
    always @(posedge CLK) begin
        bit ups, dns, held, rep, up_dir, ok;
        int d;
        if (RST) begin
            armed = 1; pu = 0; pd = 0; hk = 0;
            for (int i = 0; i < NM; i++) begin
                m_val[i] = rs[i]; m_carry[i] = 0; m_dirty[i] = 0; m_lerr[i] = 0;
            end
        end else begin
            ups  = UP && !pu;
            dns  = DOWN && !pd && !UP;
            held = Mod && ((UP && pu && !DOWN) || (DOWN && pd && !UP));
            hk   = held ? hk + 1 : 0;
            d    = int'(DATA_in[7:4]) * 10 + int'(DATA_in[3:0]);
            for (int i = 0; i < NM; i++) begin
                rep = 0;
`ifdef BCD_FIELD_AUTO_REPEAT_EN
                rep = held && (hk == dly[i] || (hk > dly[i] && (hk - dly[i]) % per[i] == 0));
`endif
                ok = DATA_in[7:4] <= 9 && DATA_in[3:0] <= 9 && d >= mn[i] && d <= mx[i];
                m_carry[i] = 0;
                m_lerr[i]  = 0;
                if (Mod && (ups || dns || rep)) begin
                    up_dir = ups || (rep && UP);
                    if (up_dir) m_val[i] = (m_val[i] == mx[i]) ? mn[i] : m_val[i] + 1;
                    else        m_val[i] = (m_val[i] == mn[i]) ? mx[i] : m_val[i] - 1;
                    m_dirty[i] = 1;
                end else begin
                    if (WR_ACK) m_dirty[i] = 0;
                    if (!Mod && Act) begin
                        if (ok) begin m_val[i] = d; m_dirty[i] = 0; end
                        else m_lerr[i] = 1;
                    end else if (!Mod && TICK) begin
                        if (m_val[i] == mx[i]) begin m_val[i] = mn[i]; m_carry[i] = 1; end
                        else m_val[i] = m_val[i] + 1;
                    end
                end
            end
            pu = UP;
            pd = DOWN;
        end
    end

    always @(negedge CLK) begin
        if (armed) begin
            for (int i = 0; i < NM; i++) begin
                cmp($sformatf("model data%0d", i), dout[i], to_bcd(m_val[i]));
                cmp($sformatf("model carry%0d", i), {7'd0, carry[i]}, {7'd0, m_carry[i]});
                cmp($sformatf("model dirty%0d", i), {7'd0, dirty[i]}, {7'd0, m_dirty[i]});
                cmp($sformatf("model lerr%0d", i), {7'd0, lerr[i]}, {7'd0, m_lerr[i]});
            end
        end
    end

    task automatic cyc(input logic m, u, dn, a, t, w, input logic [7:0] di);
        Mod = m; UP = u; DOWN = dn; Act = a; TICK = t; WR_ACK = w; DATA_in = di;
        @(negedge CLK);
        #1;
    endtask

    initial begin
        RST = 1; UP = 0; DOWN = 0; Mod = 0; Act = 0; TICK = 0; WR_ACK = 0; DATA_in = 0;
        @(negedge CLK);
        #1;
        RST = 0;
        cmp("rst a", dout[0], 8'h00);
        cmp("rst b", dout[1], 8'h01);
        cmp("rst dirty", {7'd0, dirty[0]}, 8'h00);
        cmp("rst carry", {7'd0, carry[0]}, 8'h00);
        repeat (23) cyc(1, 1, 0, 0, 0, 0, 8'h00);
        cmp("hold a", dout[0], 8'h01);
        cmp("hold b", dout[1], 8'h02);
        cmp("hold dirty", {7'd0, dirty[0]}, 8'h01);
`ifdef BCD_FIELD_AUTO_REPEAT_EN
        cmp("repeat r", dout[2], 8'h05);
`endif
        cyc(1, 0, 0, 0, 0, 0, 8'h00);
        cyc(0, 0, 0, 1, 0, 0, 8'h59);
        cmp("load59 a", dout[0], 8'h59);
        cmp("load59 dirty", {7'd0, dirty[0]}, 8'h00);
        cmp("load59 b err", {7'd0, lerr[1]}, 8'h01);
        cmp("load59 b hold", dout[1], 8'h02);
        cyc(1, 1, 0, 0, 0, 0, 8'h00);
        cmp("up wrap a", dout[0], 8'h00);
        cmp("up wrap carry", {7'd0, carry[0]}, 8'h00);
        cyc(1, 0, 0, 0, 0, 0, 8'h00);
        cyc(1, 0, 1, 0, 0, 0, 8'h00);
        cmp("dn wrap a", dout[0], 8'h59);
        cyc(1, 0, 0, 0, 0, 0, 8'h00);
        cyc(0, 0, 0, 1, 0, 0, 8'h10);
        cyc(1, 0, 1, 0, 0, 0, 8'h00);
        cmp("dn 10 a", dout[0], 8'h09);
        cmp("dn 10 b", dout[1], 8'h09);
        cyc(1, 0, 0, 0, 0, 0, 8'h00);
        cyc(0, 0, 0, 1, 0, 0, 8'h01);
        cyc(1, 0, 1, 0, 0, 0, 8'h00);
        cmp("dn min b", dout[1], 8'h12);
        cyc(1, 0, 0, 0, 0, 0, 8'h00);
        cyc(0, 0, 0, 1, 0, 0, 8'h12);
        cyc(0, 0, 0, 0, 1, 0, 8'h00);
        cmp("tick wrap b", dout[1], 8'h01);
        cmp("tick carry b", {7'd0, carry[1]}, 8'h01);
        cmp("tick a", dout[0], 8'h13);
        cyc(0, 0, 0, 0, 0, 0, 8'h00);
        cmp("carry end b", {7'd0, carry[1]}, 8'h00);
        cyc(0, 0, 0, 1, 0, 0, 8'h09);
        cyc(0, 0, 0, 0, 1, 0, 8'h00);
        cmp("tick 09 b", dout[1], 8'h10);
        cmp("tick 09 carry", {7'd0, carry[1]}, 8'h00);
        cyc(0, 0, 0, 1, 0, 0, 8'h45);
        cmp("load45 a", dout[0], 8'h45);
        cyc(0, 0, 0, 1, 0, 0, 8'h4A);
        cmp("load4A err", {7'd0, lerr[0]}, 8'h01);
        cmp("load4A hold", dout[0], 8'h45);
        cyc(0, 0, 0, 0, 0, 0, 8'h00);
        cmp("err end", {7'd0, lerr[0]}, 8'h00);
        cyc(0, 0, 0, 1, 0, 0, 8'h60);
        cmp("load60 err", {7'd0, lerr[0]}, 8'h01);
        cyc(0, 0, 0, 1, 1, 0, 8'h05);
        cmp("load beats tick", dout[0], 8'h05);
        cyc(1, 1, 1, 0, 0, 0, 8'h00);
        cmp("up wins", dout[0], 8'h06);
        cyc(1, 0, 0, 0, 0, 0, 8'h00);
        cyc(1, 1, 0, 0, 0, 1, 8'h00);
        cmp("step+ack dirty", {7'd0, dirty[0]}, 8'h01);
        cyc(1, 0, 0, 0, 0, 1, 8'h00);
        cmp("ack dirty", {7'd0, dirty[0]}, 8'h00);
        cyc(1, 0, 0, 1, 0, 0, 8'h33);
        cmp("load in edit", dout[0], 8'h07);
        cyc(1, 0, 0, 0, 1, 0, 8'h00);
        cmp("tick in edit", dout[0], 8'h07);
        cyc(0, 1, 0, 0, 0, 0, 8'h00);
        cyc(0, 1, 0, 0, 0, 0, 8'h00);
        cyc(1, 1, 0, 0, 0, 0, 8'h00);
        cmp("held into edit", dout[0], 8'h07);
        cyc(1, 0, 0, 0, 0, 0, 8'h00);
        cyc(1, 1, 0, 0, 0, 0, 8'h00);
        cmp("pre reset", dout[0], 8'h08);
        RST = 1;
        cyc(1, 1, 0, 0, 0, 0, 8'h00);
        RST = 0;
        cmp("mid reset a", dout[0], 8'h00);
        cmp("mid reset dirty", {7'd0, dirty[0]}, 8'h00);
        repeat (2) cyc(1, 0, 0, 0, 0, 0, 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
